// File: rtl/spi_slave.sv
// SPI slave with a synchronized SCLK/ss/MOSI front end, configurable mode and word size.
// Supports back-to-back words under one ss assertion and flags words cut short by ss.
`timescale 1ns/1ps
module spi_slave #(
    parameter logic [1:0] mode      = 2'b00,
    parameter int         bits_size = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SCLK,
    input  logic                 ss,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 miso_en,
    input  logic [bits_size-1:0] data_in,
    input  logic                 tx_load,
    output logic [bits_size-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic cpol = mode[1];
    localparam logic cpha = mode[0];
    localparam int   CW   = (bits_size > 2) ? $clog2(bits_size) : 1;
    localparam logic [CW-1:0] cnt_last = CW'(bits_size - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                 state_r, next_state_s;
    logic                   sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic                   ss_meta_r, ss_sync_r, ss_prev_r;
    logic                   mosi_meta_r, mosi_sync_r;
    logic [2:0]             warm_r;
    logic [CW-1:0]          bit_cnt_r;
    logic                   seen_r;
    logic [bits_size-1:0]   tx_buf_r, tx_shift_r, data_out_r;
    logic [bits_size-2:0]   rx_shift_r;
    logic                   miso_r, miso_en_r, busy_r, rx_done_r, frame_err_r;

    logic                   sclk_rise_s, sclk_fall_s, lead_s, trail_s;
    logic                   sample_s, shift_s, ss_fall_s, ss_rise_s;
    logic                   word_done_s, abort_err_s;
    logic [bits_size-1:0]   tx_src_s, rx_word_s;

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
    assign lead_s      = cpol ? sclk_fall_s : sclk_rise_s;
    assign trail_s     = cpol ? sclk_rise_s : sclk_fall_s;
    assign sample_s    = cpha ? trail_s : lead_s;
    assign shift_s     = cpha ? lead_s : trail_s;
    // warm_r keeps the post-reset synchronizer preset from looking like a fresh ss fall
    assign ss_fall_s   = warm_r[2] & ss_prev_r & ~ss_sync_r;
    assign ss_rise_s   = ss_sync_r & ~ss_prev_r;
    assign tx_src_s    = tx_load ? data_in : tx_buf_r;
    assign rx_word_s   = {rx_shift_r, mosi_sync_r};

    assign MISO      = miso_r;
    assign miso_en   = miso_en_r;
    assign busy      = busy_r;
    assign data_out  = data_out_r;
    assign rx_done   = rx_done_r;
    assign frame_err = frame_err_r;

    // Input synchronizers and SCLK/ss edge-history flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta_r <= cpol;
            sclk_sync_r <= cpol;
            sclk_prev_r <= cpol;
            ss_meta_r   <= 1'b1;
            ss_sync_r   <= 1'b1;
            ss_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            warm_r      <= 3'b000;
        end else begin
            sclk_meta_r <= SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            ss_meta_r   <= ss;
            ss_sync_r   <= ss_meta_r;
            ss_prev_r   <= ss_sync_r;
            mosi_meta_r <= MOSI;
            mosi_sync_r <= mosi_meta_r;
            warm_r      <= {warm_r[1:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state; a final sample coinciding with ss rise completes rather than errors
    always_comb begin
        next_state_s = state_r;
        word_done_s  = 1'b0;
        abort_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) begin
                    next_state_s = ACTIVE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACTIVE: begin
                word_done_s = sample_s && (bit_cnt_r == {CW{1'b0}});
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                    abort_err_s  = !word_done_s &&
                                   ((bit_cnt_r != cnt_last) || seen_r || sample_s);
                end else begin
                    next_state_s = ACTIVE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter, transmit buffer and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r   <= cnt_last;
            seen_r      <= 1'b0;
            tx_buf_r    <= {bits_size{1'b0}};
            tx_shift_r  <= {bits_size{1'b0}};
            rx_shift_r  <= {(bits_size-1){1'b0}};
            data_out_r  <= {bits_size{1'b0}};
            miso_r      <= 1'b0;
            miso_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
            miso_en_r   <= (next_state_s == ACTIVE);
            busy_r      <= (next_state_s == ACTIVE);
            if (tx_load) begin
                tx_buf_r <= data_in;
            end
            case (state_r)
                IDLE: begin
                    miso_r <= 1'b0;
                    if (ss_fall_s) begin
                        bit_cnt_r  <= cnt_last;
                        seen_r     <= 1'b0;
                        tx_shift_r <= tx_src_s;
                        miso_r     <= tx_src_s[bits_size-1];
                    end
                end
                ACTIVE: begin
                    if (word_done_s) begin
                        data_out_r <= rx_word_s;
                        rx_done_r  <= 1'b1;
                        rx_shift_r <= rx_word_s[bits_size-2:0];
                        bit_cnt_r  <= cnt_last;
                        seen_r     <= 1'b0;
                        tx_shift_r <= tx_src_s;
                        if (!cpha) begin
                            miso_r <= tx_src_s[bits_size-1];
                        end
                    end else if (sample_s) begin
                        rx_shift_r <= rx_word_s[bits_size-2:0];
                        seen_r     <= 1'b1;
                        bit_cnt_r  <= bit_cnt_r - CW'(1'b1);
                    end else if (shift_s && seen_r) begin
                        tx_shift_r <= {tx_shift_r[bits_size-2:0], 1'b0};
                        miso_r     <= tx_shift_r[bits_size-2];
                    end else if (shift_s) begin
                        // first shift edge of a word only presents the MSB
                        miso_r <= tx_shift_r[bits_size-1];
                    end
                    if (ss_rise_s) begin
                        frame_err_r <= abort_err_s;
                        miso_r      <= 1'b0;
                        bit_cnt_r   <= cnt_last;
                        seen_r      <= 1'b0;
                    end
                end
                default: begin
                    miso_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
